uart_frame_unpacker: RTL and testbench
======================================

Name: uart_frame_unpacker

Overview:
Sits between the UART receiver and the DDR fill/FIFO stage. Takes raw received bytes (rxdata/rdsig) and parses framed host downloads: header, length, big-endian 32-bit payload words and a checksum. It streams assembled words downstream over a valid/ready handshake and reports frame completion or error. This replaces raw byte-by-byte loading of sample/alpha data.

Parameters:
MAX_WORDS, 1024, largest accepted payload length in 32-bit words.
TIMEOUT_CYC, 4096, clk cycles allowed between consecutive bytes inside a frame.
HDR0, 8'hAA, first header byte.
HDR1, 8'h55, second header byte.

Ports:
clk  input  1  UART-domain clock, the same clock that drives the receiver.
reset  input  1  synchronous, active-high reset.
rdsig  input  1  receiver byte-valid; a byte is taken on its rising edge only.
rxdata  input  8  received byte, valid when rdsig rises.
dataerror  input  1  receiver parity error for the current byte.
frameerror  input  1  receiver stop-bit error for the current byte.
word_data  output  32  assembled payload word.
word_valid  output  1  word_data holds a word not yet accepted.
word_ready  input  1  downstream accepts the word when it is high together with word_valid.
word_idx  output  16  zero-based index of the word currently on word_data.
frame_len  output  16  length field of the current or last frame.
frame_busy  output  1  high from HDR0 acceptance until the frame ends.
frame_done  output  1  one-cycle pulse when a frame passes its checksum.
frame_err  output  1  one-cycle pulse when a frame is aborted.
err_code  output  3  last error: 0 none, 1 checksum, 2 bad length, 3 line error, 4 timeout, 5 overflow.

Behaviour:
- Reset: all outputs are 0 and the state machine is S_H0. The rdsig edge register is loaded with the current rdsig, so a byte already in progress at reset is not seen as a new byte. Reset in the middle of a frame drops the frame and raises no pulse.
- Byte strobe: byte_stb = rdsig & ~rdsig_q. All parsing below acts only on cycles where byte_stb is 1.
- States:
  - S_H0: byte == HDR0 -> S_H1 and frame_busy=1. Any other byte is ignored.
  - S_H1: byte == HDR1 -> S_LH. byte == HDR0 -> stay in S_H1. Any other byte -> S_H0 with no error.
  - S_LH: length high byte -> S_LL.
  - S_LL: length low byte; load frame_len.
    - Length 0 or length > MAX_WORDS -> error 2.
    - Otherwise -> S_PAY with byte counter = 0 and word_idx = 0.
  - S_PAY: shift the byte into the assembly register, MSB first. On the 4th byte of a word, load word_data and set word_valid. After the last byte of word frame_len-1 -> S_CK.
  - S_CK: checksum byte. Good sum -> frame_done pulse, err_code=0, -> S_H0. Bad sum -> error 1.
- Checksum: 8-bit sum mod 256 of both length bytes, all payload bytes and the checksum byte. The frame is good when this sum equals 8'h00.
- Handshake:
  - word_valid stays high and word_data/word_idx stay stable until a cycle with word_ready=1. That cycle clears word_valid, and word_idx increments on the next cycle.
  - The word completes 1 cycle after the byte_stb of its 4th byte.
  - A word completing while the previous word_valid is still high -> error 5. The pending word is held until it is accepted.
- Words are forwarded before the checksum is known. Downstream must discard the whole frame on frame_err.
- Line error: byte_stb with dataerror or frameerror high while frame_busy=1 -> error 3. The same condition in S_H0 is ignored.
- Timeout:
  - A 16-bit counter clears on every byte_stb and increments while frame_busy=1.
  - Reaching TIMEOUT_CYC -> error 4.
  - The counter saturates and never wraps.
- Error action, same cycle for every error:
  - frame_err pulses for 1 cycle and err_code is loaded.
  - frame_busy=0 and the state returns to S_H0.
  - word_valid is left as is; a pending word still completes its handshake.
- Priority when conditions fall on the same cycle: line error > timeout > length/overflow > checksum.
- err_code holds its value until the next frame ends or reset.
- The byte counter and word_idx are 16 bits, so no wrap occurs for MAX_WORDS ≤ 16383.

Test Plan:
- Good frame, word_ready tied 1: AA 55 00 02 11 22 33 44 A1 B2 C3 D4 CS -> words 0x11223344 (idx 0) then 0xA1B2C3D4 (idx 1), then frame_done=1 for one cycle and err_code=0. CS = 2's complement of the byte sum.
- Same frame with a wrong CS, e.g. CS+1 -> both words delivered, then frame_err=1 and err_code=1. A following valid frame is still accepted.
- Length 0x0000 -> err_code=2. Length MAX_WORDS+1 -> err_code=2. In both cases no word_valid is raised.
- Header resync: bytes 00 AA AA 55 00 01 DE AD BE EF CS -> frame accepted with one word 0xDEADBEEF.
- word_ready held 0 through a 2-word frame -> first word held stable, frame_err with err_code=5 at completion of the 2nd word. Raising word_ready then clears word_valid.
- Stop after 3 payload bytes for TIMEOUT_CYC cycles -> frame_err and err_code=4.
- Separately, frameerror=1 on a payload byte -> frame_err and err_code=3.
- Separately, reset mid-payload -> all outputs 0 and no pulse.

Source files
------------

// File: rtl/uart_frame_unpacker.sv
// -----------------------------------------------------------------------------
// uart_frame_unpacker
//
// Parses framed host downloads arriving byte-by-byte from the UART receiver
// and streams the 32-bit payload words to the DDR fill / FIFO stage.
//
// Frame layout (one byte per rdsig rising edge):
//   HDR0 HDR1 LEN_HI LEN_LO {W0[31:24] W0[23:16] W0[15:8] W0[7:0]} ... CS
// CS makes the 8-bit sum of LEN_HI, LEN_LO, all payload bytes and CS equal 0.
//
// Ports
//   clk         UART-domain clock (same clock as the receiver)
//   reset       synchronous, active-high reset
//   rdsig       receiver byte-valid; a byte is taken on its rising edge only
//   rxdata      received byte, valid when rdsig rises
//   dataerror   receiver parity error for the current byte
//   frameerror  receiver stop-bit error for the current byte
//   word_data   assembled payload word (big-endian byte order)
//   word_valid  word_data holds a word not yet accepted
//   word_ready  downstream accepts the word when high together with word_valid
//   word_idx    zero-based index of the word currently on word_data
//   frame_len   length field of the current or last frame
//   frame_busy  high from HDR0 acceptance until the frame ends
//   frame_done  one-cycle pulse when a frame passes its checksum
//   frame_err   one-cycle pulse when a frame is aborted
//   err_code    last error: 0 none, 1 checksum, 2 bad length, 3 line error,
//               4 timeout, 5 overflow
//
// Words are forwarded before the checksum is known; downstream must discard
// the whole frame when frame_err pulses.
// -----------------------------------------------------------------------------
module uart_frame_unpacker #(
    parameter int unsigned MAX_WORDS   = 1024,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter logic [7:0]  HDR0        = 8'hAA,
    parameter logic [7:0]  HDR1        = 8'h55
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdsig,
    input  logic [7:0]  rxdata,
    input  logic        dataerror,
    input  logic        frameerror,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [15:0] word_idx,
    output logic [15:0] frame_len,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [2:0]  err_code
);

    typedef enum logic [2:0] {
        S_H0  = 3'd0,
        S_H1  = 3'd1,
        S_LH  = 3'd2,
        S_LL  = 3'd3,
        S_PAY = 3'd4,
        S_CK  = 3'd5
    } state_t;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_CSUM = 3'd1;
    localparam logic [2:0] ERR_LEN  = 3'd2;
    localparam logic [2:0] ERR_LINE = 3'd3;
    localparam logic [2:0] ERR_TOUT = 3'd4;
    localparam logic [2:0] ERR_OVFL = 3'd5;

    localparam logic [31:0] MAX_W32 = MAX_WORDS;
    // Timeout limit clipped to the 16-bit counter range.
    localparam logic [15:0] TO_LIM  = (TIMEOUT_CYC > 32'd65535) ? 16'hFFFF
                                                                : TIMEOUT_CYC[15:0];

    // Running modulo-256 checksum accumulation.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    // A length field is acceptable when it is non-zero and within MAX_WORDS.
    function automatic logic len_is_bad(input logic [15:0] len);
        return (len == 16'd0) || ({16'd0, len} > MAX_W32);
    endfunction

    state_t      state_r;
    logic        rdsig_q_r;
    logic [7:0]  len_hi_r;
    logic [7:0]  sum_r;
    logic [23:0] asm_r;
    logic [15:0] byte_cnt_r;
    logic [15:0] pay_last_r;
    logic [15:0] to_cnt_r;

    logic        byte_stb_s;
    logic        accept_s;
    logic [15:0] len_s;
    logic        len_bad_s;
    logic [7:0]  sum_next_s;
    logic        word_end_s;
    logic        last_byte_s;
    logic        overflow_s;
    logic        line_err_s;
    logic        timeout_s;
    logic        err_s;
    logic [2:0]  err_kind_s;

    // Byte strobe, handshake and per-byte condition decode.
    always_comb begin
        byte_stb_s  = rdsig & ~rdsig_q_r;
        accept_s    = word_valid & word_ready;
        len_s       = {len_hi_r, rxdata};
        len_bad_s   = len_is_bad(len_s);
        sum_next_s  = csum_add(sum_r, rxdata);
        word_end_s  = (state_r == S_PAY) && (byte_cnt_r[1:0] == 2'b11);
        last_byte_s = (byte_cnt_r == pay_last_r);
        // A completed word may replace the pending one only if that one is
        // being accepted on this very cycle.
        overflow_s  = word_end_s & word_valid & ~word_ready;
        line_err_s  = byte_stb_s & (dataerror | frameerror) & frame_busy;
        timeout_s   = frame_busy & (to_cnt_r >= TO_LIM);
    end

    // Error arbitration: line > timeout > length/overflow > checksum.
    always_comb begin
        err_s      = 1'b0;
        err_kind_s = ERR_NONE;
        if (line_err_s) begin
            err_s      = 1'b1;
            err_kind_s = ERR_LINE;
        end else if (timeout_s) begin
            err_s      = 1'b1;
            err_kind_s = ERR_TOUT;
        end else if (byte_stb_s && (state_r == S_LL) && len_bad_s) begin
            err_s      = 1'b1;
            err_kind_s = ERR_LEN;
        end else if (byte_stb_s && overflow_s) begin
            err_s      = 1'b1;
            err_kind_s = ERR_OVFL;
        end else if (byte_stb_s && (state_r == S_CK) && (sum_next_s != 8'h00)) begin
            err_s      = 1'b1;
            err_kind_s = ERR_CSUM;
        end else begin
            err_s      = 1'b0;
            err_kind_s = ERR_NONE;
        end
    end

    // Inter-byte timeout counter: cleared by every byte, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_r <= 16'd0;
        end else if (byte_stb_s || !frame_busy) begin
            to_cnt_r <= 16'd0;
        end else if (to_cnt_r != 16'hFFFF) begin
            to_cnt_r <= to_cnt_r + 16'd1;
        end
    end

    // Frame parser state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Preload the edge register so a byte in flight is not re-taken.
            rdsig_q_r  <= rdsig;
            state_r    <= S_H0;
            len_hi_r   <= 8'd0;
            sum_r      <= 8'd0;
            asm_r      <= 24'd0;
            byte_cnt_r <= 16'd0;
            pay_last_r <= 16'd0;
            word_data  <= 32'd0;
            word_valid <= 1'b0;
            word_idx   <= 16'd0;
            frame_len  <= 16'd0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            rdsig_q_r  <= rdsig;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            // Downstream handshake; the index advances with the acceptance.
            if (accept_s) begin
                word_valid <= 1'b0;
                word_idx   <= word_idx + 16'd1;
            end

            if (err_s) begin
                // Abort: the pending word (if any) is left to finish its
                // handshake, the new byte is discarded.
                frame_err  <= 1'b1;
                err_code   <= err_kind_s;
                frame_busy <= 1'b0;
                state_r    <= S_H0;
                if (err_kind_s == ERR_LEN) begin
                    frame_len <= len_s;
                end
            end else if (byte_stb_s) begin
                case (state_r)
                    S_H0: begin
                        if (rxdata == HDR0) begin
                            state_r    <= S_H1;
                            frame_busy <= 1'b1;
                        end
                    end
                    S_H1: begin
                        if (rxdata == HDR1) begin
                            state_r <= S_LH;
                        end else if (rxdata == HDR0) begin
                            // Repeated HDR0: it may be the real start.
                            state_r <= S_H1;
                        end else begin
                            state_r    <= S_H0;
                            frame_busy <= 1'b0;
                        end
                    end
                    S_LH: begin
                        len_hi_r <= rxdata;
                        sum_r    <= rxdata;
                        state_r  <= S_LL;
                    end
                    S_LL: begin
                        frame_len  <= len_s;
                        sum_r      <= sum_next_s;
                        byte_cnt_r <= 16'd0;
                        word_idx   <= 16'd0;
                        // Index of the final payload byte: 4*len - 1.
                        pay_last_r <= {len_s[13:0], 2'b00} - 16'd1;
                        state_r    <= S_PAY;
                    end
                    S_PAY: begin
                        sum_r      <= sum_next_s;
                        asm_r      <= {asm_r[15:0], rxdata};
                        byte_cnt_r <= byte_cnt_r + 16'd1;
                        if (word_end_s) begin
                            word_data  <= {asm_r, rxdata};
                            word_valid <= 1'b1;
                        end
                        if (last_byte_s) begin
                            state_r <= S_CK;
                        end
                    end
                    S_CK: begin
                        // Reaching here means the sum came out to zero.
                        frame_done <= 1'b1;
                        err_code   <= ERR_NONE;
                        frame_busy <= 1'b0;
                        state_r    <= S_H0;
                    end
                    default: begin
                        frame_busy <= 1'b0;
                        state_r    <= S_H0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_unpacker.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_unpacker
//
// Directed frames with hand-computed words and checksums. Stimulus pushes the
// expected words and frame-end events into queues; a monitor on the falling
// clock edge pops and compares whenever the DUT hands over a word or pulses
// frame_done / frame_err.
// -----------------------------------------------------------------------------
module tb_uart_frame_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic        rdsig;
    logic [7:0]  rxdata;
    logic        dataerror;
    logic        frameerror;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic [15:0] word_idx;
    logic [15:0] frame_len;
    logic        frame_busy;
    logic        frame_done;
    logic        frame_err;
    logic [2:0]  err_code;

    int checks      = 0;
    int failures    = 0;
    int events_seen = 0;
    int ev_target   = 0;

    logic [31:0] exp_data[$];
    logic [15:0] exp_idx[$];
    logic        exp_kind[$];   // 0 = frame_done, 1 = frame_err
    logic [2:0]  exp_code[$];
    logic [7:0]  bytes_q[$];

    logic [31:0] m_data;
    logic [15:0] m_idx;
    logic        m_kind;
    logic [2:0]  m_code;

    uart_frame_unpacker #(
        .MAX_WORDS   (1024),
        .TIMEOUT_CYC (4096),
        .HDR0        (8'hAA),
        .HDR1        (8'h55)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rdsig      (rdsig),
        .rxdata     (rxdata),
        .dataerror  (dataerror),
        .frameerror (frameerror),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_idx   (word_idx),
        .frame_len  (frame_len),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Scoreboard monitor: compares accepted words and frame-end pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (word_valid && word_ready) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word got=%h idx=%0d expected=none", word_data, word_idx);
                end else begin
                    m_data = exp_data.pop_front();
                    m_idx  = exp_idx.pop_front();
                    chk("word_data", word_data, m_data);
                    chk("word_idx", 32'(word_idx), 32'(m_idx));
                end
            end
            if (frame_done || frame_err) begin
                events_seen++;
                if (exp_kind.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event got=done:%0b err:%0b code:%0d expected=none",
                             frame_done, frame_err, err_code);
                end else begin
                    m_kind = exp_kind.pop_front();
                    m_code = exp_code.pop_front();
                    chk("ev_done", 32'(frame_done), 32'(!m_kind));
                    chk("ev_err", 32'(frame_err), 32'(m_kind));
                    chk("ev_code", 32'(err_code), 32'(m_code));
                end
            end
        end
    end

    task automatic expect_word(input logic [31:0] d, input logic [15:0] idx);
        exp_data.push_back(d);
        exp_idx.push_back(idx);
    endtask

    task automatic expect_event(input logic kind, input logic [2:0] code);
        exp_kind.push_back(kind);
        exp_code.push_back(code);
        ev_target++;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        @(posedge clk); #1;
        rxdata     = b;
        frameerror = fe;
        rdsig      = 1'b1;
        @(posedge clk); #1;
        rdsig      = 1'b0;
        frameerror = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_q();
        foreach (bytes_q[i]) send_byte(bytes_q[i], 1'b0);
    endtask

    task automatic wait_events(input string nm);
        int n;
        n = 0;
        while (events_seen < ev_target && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (events_seen < ev_target) begin
            failures++;
            $display("FAIL %s_wait got=%0d expected=%0d", nm, events_seen, ev_target);
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_valid"}, 32'(word_valid), 32'd0);
        chk({nm, "_data"},  word_data,       32'd0);
        chk({nm, "_idx"},   32'(word_idx),   32'd0);
        chk({nm, "_len"},   32'(frame_len),  32'd0);
        chk({nm, "_busy"},  32'(frame_busy), 32'd0);
        chk({nm, "_done"},  32'(frame_done), 32'd0);
        chk({nm, "_err"},   32'(frame_err),  32'd0);
        chk({nm, "_code"},  32'(err_code),   32'd0);
    endtask

    initial begin
        int n;
        int start;
        reset      = 1'b1;
        rdsig      = 1'b0;
        rxdata     = 8'h00;
        dataerror  = 1'b0;
        frameerror = 1'b0;
        word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_idle_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Good 2-word frame: sum(00 02 payload) = 0x96, CS = 0x6A.
        expect_word(32'h11223344, 16'd0);
        expect_word(32'hA1B2C3D4, 16'd1);
        expect_event(1'b0, 3'd0);
        bytes_q = '{8'hAA, 8'h55, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                    8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h6A};
        send_q();
        wait_events("good");
        chk("good_len", 32'(frame_len), 32'd2);
        chk("good_busy", 32'(frame_busy), 32'd0);

        // Same frame with CS+1: words still forwarded, then checksum error.
        expect_word(32'h11223344, 16'd0);
        expect_word(32'hA1B2C3D4, 16'd1);
        expect_event(1'b1, 3'd1);
        bytes_q[12] = 8'h6B;
        send_q();
        wait_events("bad_cs");

        // A following valid frame is still accepted and clears err_code.
        expect_word(32'h11223344, 16'd0);
        expect_word(32'hA1B2C3D4, 16'd1);
        expect_event(1'b0, 3'd0);
        bytes_q[12] = 8'h6A;
        send_q();
        wait_events("good_again");

        // Length 0 and length MAX_WORDS+1 (0x0401): bad length, no words.
        expect_event(1'b1, 3'd2);
        bytes_q = '{8'hAA, 8'h55, 8'h00, 8'h00};
        send_q();
        wait_events("len_zero");
        chk("len_zero_len", 32'(frame_len), 32'd0);
        chk("len_zero_valid", 32'(word_valid), 32'd0);

        expect_event(1'b1, 3'd2);
        bytes_q = '{8'hAA, 8'h55, 8'h04, 8'h01};
        send_q();
        wait_events("len_big");
        chk("len_big_len", 32'(frame_len), 32'h0401);
        chk("len_big_valid", 32'(word_valid), 32'd0);

        // Header resync: sum(00 01 DE AD BE EF) = 0x39, CS = 0xC7.
        expect_word(32'hDEADBEEF, 16'd0);
        expect_event(1'b0, 3'd0);
        bytes_q = '{8'h00, 8'hAA, 8'hAA, 8'h55, 8'h00, 8'h01,
                    8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC7};
        send_q();
        wait_events("resync");

        // Back-pressure: second word completes on a pending first word.
        word_ready = 1'b0;
        expect_event(1'b1, 3'd5);
        bytes_q = '{8'hAA, 8'h55, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                    8'h05, 8'h06, 8'h07, 8'h08};
        send_q();
        wait_events("overflow");
        chk("ovf_hold_valid", 32'(word_valid), 32'd1);
        chk("ovf_hold_data", word_data, 32'h01020304);
        chk("ovf_hold_idx", 32'(word_idx), 32'd0);
        chk("ovf_busy", 32'(frame_busy), 32'd0);
        expect_word(32'h01020304, 16'd0);
        @(posedge clk); #1;
        word_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("ovf_release_valid", 32'(word_valid), 32'd0);

        // Inter-byte timeout after 3 payload bytes.
        expect_event(1'b1, 3'd4);
        bytes_q = '{8'hAA, 8'h55, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
        send_q();
        start = events_seen;
        n = 0;
        while (events_seen == start && n < 6000) begin
            @(posedge clk);
            n++;
        end
        chk("timeout_seen", 32'(events_seen != start), 32'd1);
        chk("timeout_window", 32'((n >= 4094) && (n <= 4098)), 32'd1);
        repeat (3) @(posedge clk);

        // Stop-bit error on a payload byte.
        expect_event(1'b1, 3'd3);
        bytes_q = '{8'hAA, 8'h55, 8'h00, 8'h01, 8'h11};
        send_q();
        send_byte(8'h22, 1'b1);
        wait_events("line_err");

        // Reset mid-payload with rdsig already high: no pulse, no byte taken.
        bytes_q = '{8'hAA, 8'h55, 8'h00, 8'h01, 8'h11, 8'h22};
        send_q();
        @(posedge clk); #1;
        reset  = 1'b1;
        rxdata = 8'hAA;
        rdsig  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_idle_zero("midreset");
        rdsig = 1'b0;

        expect_word(32'hDEADBEEF, 16'd0);
        expect_event(1'b0, 3'd0);
        bytes_q = '{8'hAA, 8'h55, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC7};
        send_q();
        wait_events("after_reset");

        chk("words_left", 32'(exp_data.size()), 32'd0);
        chk("events_left", 32'(exp_kind.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
